fetch_sequencer: RTL

Front-end controller that drives the word-indexed PC into the instruction queue.
- Sequences linear fetch.
- Holds the PC on back-pressure from the issue stage.
- Takes redirects from branch resolution or the ROB and raises a one-cycle flush.
- Stops fetch on a decoded halt or when the PC leaves instruction-memory range.
- Sits between the commit/branch logic and the instruction queue. Updates on posedge clk; the queue samples PC on negedge, so PC is stable half a cycle before sampling.

---
 rtl/fetch_sequencer_pkg.sv | 18 +
 rtl/fetch_sequencer_perf_counters.sv | 53 +++++
 rtl/fetch_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared constants and FSM state encoding for the fetch front end.
// The instruction queue imports IMEM_DEPTH from here so both sides agree on range.
package fetch_sequencer_pkg;

    localparam int unsigned PC_WIDTH   = 32;
    localparam int unsigned IMEM_DEPTH = 1024;
    localparam int unsigned RESET_PC   = 0;
    localparam int unsigned CNT_WIDTH  = 32;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_STALL    = 3'd2,
        S_REDIRECT = 3'd3,
        S_DONE     = 3'd4
    } state_e;

endpackage : fetch_sequencer_pkg

// File: rtl/fetch_sequencer_perf_counters.sv
// Saturating performance counter bank for the fetch sequencer.
// Only instantiated when FETCH_PERF_COUNTERS_EN is defined.
module fetch_perf_counters
    import fetch_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_inc,
    input  logic                 stall_inc,
    input  logic                 redirect_inc,
    output logic [CNT_WIDTH-1:0] fetch_count,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] redirect_count
);

    logic [CNT_WIDTH-1:0] fetch_count_q,    fetch_count_d;
    logic [CNT_WIDTH-1:0] stall_cycles_q,   stall_cycles_d;
    logic [CNT_WIDTH-1:0] redirect_count_q, redirect_count_d;

    // Increment each counter on its event, sticking at all-ones.
    always_comb begin
        fetch_count_d    = fetch_count_q;
        stall_cycles_d   = stall_cycles_q;
        redirect_count_d = redirect_count_q;
        if (fetch_inc && (fetch_count_q != '1)) begin
            fetch_count_d = fetch_count_q + CNT_WIDTH'(1);
        end
        if (stall_inc && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
        end
        if (redirect_inc && (redirect_count_q != '1)) begin
            redirect_count_d = redirect_count_q + CNT_WIDTH'(1);
        end
    end

    // Counter registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q    <= '0;
            stall_cycles_q   <= '0;
            redirect_count_q <= '0;
        end else begin
            fetch_count_q    <= fetch_count_d;
            stall_cycles_q   <= stall_cycles_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign fetch_count    = fetch_count_q;
    assign stall_cycles   = stall_cycles_q;
    assign redirect_count = redirect_count_q;

endmodule : fetch_perf_counters

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the word-indexed PC into the instruction queue,
// holds on stall, takes redirects with a one-cycle flush, stops on halt or
// when the PC runs off the end of instruction memory.
// Optional perf counters: define FETCH_PERF_COUNTERS_EN.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH_P = IMEM_DEPTH,
    parameter int unsigned RESET_PC_P   = RESET_PC,
    parameter int unsigned PC_WIDTH_P   = PC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_in,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH_P-1:0] redirect_pc,
    input  logic                  halt_in,
    output logic [PC_WIDTH_P-1:0] PC,
    output logic                  fetch_valid,
    output logic                  flush_out,
    output logic [2:0]            state_out,
`ifdef FETCH_PERF_COUNTERS_EN
    output logic [CNT_WIDTH-1:0]  fetch_count,
    output logic [CNT_WIDTH-1:0]  stall_cycles,
    output logic [CNT_WIDTH-1:0]  redirect_count,
`endif
    output logic                  done
);

    localparam int unsigned PCW_EXT = PC_WIDTH_P + 1;
    localparam logic [PC_WIDTH_P-1:0] LAST_PC  = PC_WIDTH_P'(IMEM_DEPTH_P - 1);
    localparam logic [PC_WIDTH_P-1:0] BOOT_PC  = PC_WIDTH_P'(RESET_PC_P);
    localparam logic [PCW_EXT-1:0]    DEPTH_EXT = PCW_EXT'(IMEM_DEPTH_P);

    state_e                  state_q, state_d;
    logic [PC_WIDTH_P-1:0]   pc_q, pc_d;
    logic                    fetch_valid_q, fetch_valid_d;
    logic                    flush_q, flush_d;
    logic                    done_q, done_d;
    logic                    pc_out_of_range_c;

    // Compare one bit wider so a depth of 2**PC_WIDTH still works.
    assign pc_out_of_range_c = ({1'b0, pc_q} >= DEPTH_EXT);

    // Next-state and registered-output logic; redirect beats everything.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = 1'b0;
        flush_d       = 1'b0;

        if (redirect_valid) begin
            state_d = S_REDIRECT;
            pc_d    = redirect_pc;
            flush_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (halt_in) begin
                        state_d = S_DONE;
                    end else if (stall_in) begin
                        state_d = S_STALL;
                    end else begin
                        state_d       = S_RUN;
                        fetch_valid_d = 1'b1;
                    end
                end
                S_RUN: begin
                    if (halt_in) begin
                        state_d = S_DONE;
                    end else if (stall_in) begin
                        state_d = S_STALL;
                    end else if (pc_q == LAST_PC) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d          = pc_q + PC_WIDTH_P'(1);
                        fetch_valid_d = 1'b1;
                    end
                end
                S_STALL: begin
                    if (halt_in) begin
                        state_d = S_DONE;
                    end else if (!stall_in) begin
                        state_d       = S_RUN;
                        fetch_valid_d = 1'b1;
                    end
                end
                S_REDIRECT: begin
                    // Stall and halt wait for the first RUN cycle after the redirect.
                    if (pc_out_of_range_c) begin
                        state_d = S_DONE;
                    end else begin
                        state_d       = S_RUN;
                        fetch_valid_d = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                    pc_d    = BOOT_PC;
                end
            endcase
        end

        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= BOOT_PC;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            done_q        <= done_d;
        end
    end

    assign PC          = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign flush_out   = flush_q;
    assign state_out   = state_q;
    assign done        = done_q;

`ifdef FETCH_PERF_COUNTERS_EN
    fetch_perf_counters u_perf (
        .clk            (clk),
        .rst            (rst),
        .fetch_inc      (fetch_valid_q),
        .stall_inc      (state_q == S_STALL),
        .redirect_inc   (redirect_valid),
        .fetch_count    (fetch_count),
        .stall_cycles   (stall_cycles),
        .redirect_count (redirect_count)
    );
`endif

endmodule : fetch_sequencer
